fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the width of each requester data word and of fifo_din.
REQ-002 Parameter NUM_REQ, default 4, sets the number of requesters; legal range is 2..8.
REQ-003 Parameter MAX_BURST, default 4, sets the maximum words accepted per grant; legal range is 1..16.
REQ-004 Port clk, input, 1 bit, is the clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1 bit, SHALL be an asynchronous, active-high reset.
REQ-006 Port req_valid, input, NUM_REQ bits: bit i high means requester i has a word to write.
REQ-007 Port req_data, input, NUM_REQ*DATA_WIDTH bits: requester i's word occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port req_ready, output, NUM_REQ bits: bit i high means requester i's word is accepted this cycle.
REQ-009 Port fifo_full, input, 1 bit, is the full flag of the downstream FIFO.
REQ-010 Port fifo_write_en, output, 1 bit, is the write strobe to the FIFO.
REQ-011 Port fifo_din, output, DATA_WIDTH bits, is the write data to the FIFO.
REQ-012 Port grant, output, NUM_REQ bits, is the registered one-hot grant; all zero when no requester is granted.
REQ-013 Port active_id, output, 3 bits, is the index of the granted requester; it is valid only while busy is high.
REQ-014 Port busy, output, 1 bit, is high while the FSM is in state BURST.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and BURST.
REQ-016 A transfer SHALL occur in any cycle where busy=1, req_valid[active_id]=1 and fifo_full=0.
REQ-017 req_ready[i] SHALL equal grant[i] & !fifo_full, combinationally; the FSM state does not enter this term.
REQ-018 fifo_write_en SHALL be high only in a transfer cycle (combinational).
REQ-019 fifo_din SHALL equal req_data for active_id in every cycle, combinationally.
REQ-020 The block SHALL never assert fifo_write_en while fifo_full=1; no word is dropped and none is duplicated.
REQ-021 Arbitration is round-robin: the search starts at (last_id+1) mod NUM_REQ and takes the first index whose req_valid bit is high.
REQ-022 last_id is the most recently granted index; it resets to NUM_REQ-1, so requester 0 has first priority after reset.
REQ-023 In IDLE, if any req_valid bit is high, the FSM SHALL arbitrate, register grant and active_id, and enter BURST on the next edge; there is 1 cycle of latency from req_valid to grant.
REQ-024 In IDLE with no req_valid bit high, the FSM SHALL stay in IDLE with grant=0.
REQ-025 burst_cnt (internal, width ceil(log2(MAX_BURST))+1) SHALL clear on every new grant and increment on every transfer.
REQ-026 The grant SHALL be released on a transfer that brings burst_cnt to MAX_BURST.
REQ-027 The grant SHALL also be released in any BURST cycle where req_valid[active_id]=0.
REQ-028 On release, the FSM SHALL re-arbitrate in the same cycle, excluding no requester.
- If any req_valid bit is high, the new grant is registered and the FSM stays in BURST (back-to-back, no idle bubble).
- Otherwise the FSM goes to IDLE.
REQ-029 A requester holding req_valid alone SHALL be re-granted after each burst of MAX_BURST words, with no gap cycle.
REQ-030 While fifo_full=1 in BURST, the grant, burst_cnt and FSM state SHALL hold; a stall does not count toward the burst.
REQ-031 Changes on req_valid bits of non-granted requesters SHALL NOT affect the current grant.
REQ-032 MAX_BURST=1 SHALL rotate the grant after every transfer.

Reset
REQ-033 Asserting reset at any time, including mid-burst, SHALL immediately (asynchronously) force the following values:
- FSM state = IDLE, grant=0, busy=0, active_id=0, burst_cnt=0, last_id=NUM_REQ-1.
- Because outputs depend on grant, this also gives req_ready=0 and fifo_write_en=0.
REQ-034 The first arbitration SHALL occur on the first rising edge after reset deasserts.

Verification
REQ-035 Single requester (default parameters): req_valid=0001 held for 10 cycles with fifo_full=0 -> grant=0001 one cycle later; fifo_write_en high every cycle thereafter; 10 words written in order; no gap at the burst boundaries (after words 4 and 8).
REQ-036 Fairness: req_valid=1111 held -> grants in the order 0,1,2,3,0, each for exactly 4 transfers; fifo_din sequence matches each requester's data in turn.
REQ-037 Backpressure: mid-burst, after 2 words, raise fifo_full for 3 cycles -> req_ready=0 and fifo_write_en=0 for those 3 cycles; grant is held; the burst resumes and completes with words 3 and 4.
REQ-038 Early drop: requester 2 is granted and drops req_valid after 1 word while requester 3 is pending -> grant moves to 0100->1000 on the next edge with no IDLE cycle.
REQ-039 Reset mid-burst: assert reset after 2 words of a burst -> grant=0, busy=0 and fifo_write_en=0 at once; after release with req_valid=1010, requester 1 is granted first.
REQ-040 Scoreboard over all scenarios: every accepted word appears exactly once on fifo_din with fifo_write_en=1, and fifo_write_en & fifo_full is never seen.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if -- bundle of the requester-side and FIFO-side signals of
// the FIFO write arbiter.
//
// Handshake: requester i offers a word by raising req_valid[i] with the word on
// its req_data slice. The word is accepted in a cycle where req_valid[i] and
// req_ready[i] are both high at the rising edge. The requester must then advance
// to its next word or drop req_valid. req_ready[i] never depends on req_valid[i].
// fifo_write_en is high exactly in the cycles where a word is accepted, with the
// word on fifo_din.
//
// Signals:
//   req_valid     requester -> arbiter, one bit per requester
//   req_data      requester -> arbiter, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready     arbiter -> requester, word accepted this cycle
//   fifo_full     FIFO -> arbiter, downstream full flag
//   fifo_write_en arbiter -> FIFO, write strobe
//   fifo_din      arbiter -> FIFO, write data
//   grant         arbiter -> observers, registered one-hot grant
//   active_id     arbiter -> observers, granted index (valid while busy)
//   busy          arbiter -> observers, FSM is in BURST
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_write_en;
  logic [DATA_WIDTH-1:0]         fifo_din;
  logic [NUM_REQ-1:0]            grant;
  logic [2:0]                    active_id;
  logic                          busy;

  // The arbiter side.
  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_write_en, fifo_din, grant, active_id, busy
  );

  // The requesters, the FIFO and any observer.
  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_write_en, fifo_din, grant, active_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter -- round-robin arbiter that lets NUM_REQ requesters share one
// FIFO write port, granting each winner for a burst of up to MAX_BURST words.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    fifo_wr_arbiter_if.slave: requester handshakes, FIFO write port,
//          grant / active_id / busy status
//
// The FSM has two states, IDLE and BURST; busy is the state bit itself, so the
// state is always visible outside the block.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic           clk,
  input  logic           reset,
  fifo_wr_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t             state, state_n;
  logic [NUM_REQ-1:0] grant_q, grant_n;
  logic [IW-1:0]      cur_id, cur_id_n;
  logic [IW-1:0]      last_id, last_id_n;
  logic [CW-1:0]      burst_cnt, burst_cnt_n;

  logic               transfer;
  logic               last_word;
  logic               release_g;
  logic               any_valid;
  logic [IW-1:0]      pick_id;

  // First requesting index at or after last+1, wrapping. The loop walks the
  // distances from farthest to nearest so the nearest valid index wins; at
  // distance NUM_REQ the search reaches last itself, which lets a lone
  // requester be re-granted.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [IW-1:0] last);
    logic [IW-1:0] res;
    int            c;
    res = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      c = (int'(last) + k) % NUM_REQ;
      if (v[IW'(c)]) res = IW'(c);
    end
    return res;
  endfunction

  assign any_valid = |bus.req_valid;
  assign pick_id   = rr_pick(bus.req_valid, last_id);
  assign transfer  = (state == BURST) && bus.req_valid[cur_id] && !bus.fifo_full;
  assign last_word = (burst_cnt + CW'(1)) == CW'(MAX_BURST);
  // A granted requester that drops req_valid gives up the grant even during a
  // stall. While it holds req_valid, a stall freezes everything.
  assign release_g = (state == BURST) &&
                     (!bus.req_valid[cur_id] || (transfer && last_word));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant_q   <= '0;
      cur_id    <= '0;
      last_id   <= IW'(NUM_REQ - 1);
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      grant_q   <= grant_n;
      cur_id    <= cur_id_n;
      last_id   <= last_id_n;
      burst_cnt <= burst_cnt_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n     = state;
    grant_n     = grant_q;
    cur_id_n    = cur_id;
    last_id_n   = last_id;
    burst_cnt_n = burst_cnt;
    case (state)
      IDLE: begin
        grant_n = '0;
        if (any_valid) begin
          state_n     = BURST;
          grant_n     = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_id;
          cur_id_n    = pick_id;
          last_id_n   = pick_id;
          burst_cnt_n = '0;
        end
      end
      BURST: begin
        if (release_g) begin
          // Re-arbitrate in the release cycle itself, so there is no gap
          // between bursts.
          if (any_valid) begin
            grant_n     = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_id;
            cur_id_n    = pick_id;
            last_id_n   = pick_id;
            burst_cnt_n = '0;
          end else begin
            state_n     = IDLE;
            grant_n     = '0;
            burst_cnt_n = '0;
          end
        end else if (transfer) begin
          burst_cnt_n = burst_cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    bus.grant         = grant_q;
    bus.busy          = (state == BURST);
    bus.active_id     = 3'(cur_id);
    bus.req_ready     = grant_q & {NUM_REQ{!bus.fifo_full}};
    bus.fifo_write_en = transfer;
    bus.fifo_din      = bus.req_data[int'(cur_id)*DATA_WIDTH +: DATA_WIDTH];
  end

endmodule
